gtp_rx_deframer: RTL and testbench
==================================

Name: gtp_rx_deframer

Overview:
- Receive-side counterpart of the framed GTP transmit path.
- Takes decoded 8b/10b symbols from the GTP RX datapath, which are byte plus K flag plus code error, in the gtp_clk domain.
- Acquires link lock on idle commas and strips SOF/EOF delimiters.
- Re-creates the 8-bit data plus 2-bit type stream (01 first, 00 middle, 10 last) that was written on the transmit side, and drives the receive FIFO write port.

Parameters:
- LOCK_COUNT, 16: consecutive K28.5 commas required to assert link_ready.
- ERR_LIMIT, 4: consecutive code-error symbols that drop lock.
- MAX_LEN, 256: maximum data bytes per frame; larger frames are aborted.

Ports:
- gtp_clk  input  1  RX user clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- rx_data  input  8  decoded symbol byte.
- rx_charisk  input  1  1 = rx_data is a K character.
- rx_err  input  1  disparity or not-in-table error for this symbol.
- rx_valid  input  1  symbol qualifier; symbols with rx_valid=0 are ignored entirely and no state changes.
- dout  output  8  recovered data byte.
- dtout  output  2  type: 01 first, 00 middle, 10 last, 11 single-byte frame.
- dout_we  output  1  one-cycle write strobe for dout/dtout.
- link_ready  output  1  lock status.
- frame_err  output  1  one-cycle pulse on a protocol violation.

Behaviour:
- Symbols: COMMA = K28.5 (0xBC,K); SOF = K27.7 (0xFB,K); EOF = K29.7 (0xFD,K). Any other K is illegal.
- Reset: all outputs 0, state UNLOCKED, comma and error counters 0, hold register empty.
  - rst mid-frame discards the partial frame with no strobe or error.
- Lock:
  - In UNLOCKED, a valid COMMA with rx_err=0 increments the comma counter; any other valid symbol clears it.
  - When the counter reaches LOCK_COUNT: link_ready=1 on the next cycle, go to IDLE.
- Loss of lock (any locked state):
  - Each valid symbol with rx_err=1 increments the error counter; a valid clean symbol clears it.
  - Reaching ERR_LIMIT: link_ready=0 next cycle, state UNLOCKED.
  - If a frame was open, pulse frame_err and discard the held byte.
  - Symbols with rx_err=1 are never treated as data or delimiters.
- IDLE:
  - COMMA: ignore.
  - SOF: go to IN_FRAME, len=0, hold empty.
  - Data or EOF: frame_err pulse, stay in IDLE.
- IN_FRAME:
  - COMMA: ignored as clock-correction fill; frame stays open.
  - Data byte:
    - If hold is full, emit the held byte with dtout=01 if it was the first byte, else 00.
    - Then load the new byte into hold; len++.
  - EOF with hold full: emit the held byte with dtout=10, or 11 if len==1; go to IDLE.
  - EOF with len==0: frame_err, go to IDLE, no strobe.
  - SOF: frame_err, discard hold, restart a new frame (stay in IN_FRAME, len=0).
  - Illegal K: frame_err, discard hold, go to IDLE.
  - Data when len==MAX_LEN: frame_err, discard hold, enter DRAIN.
- DRAIN: ignore all symbols until EOF or SOF.
  - EOF: go to IDLE.
  - SOF: start a new frame.
- Latency and strobe rules:
  - dout/dtout/dout_we are registered and appear 1 cycle after the sampling edge of the symbol that resolves the held byte's type.
  - At most one strobe per cycle.
  - dout and dtout keep their last values when dout_we=0.
- len is $clog2(MAX_LEN+1) bits wide and never wraps.

Optional Feature:
- RX_STATS_EN defined: adds outputs frame_cnt[15:0] and err_cnt[15:0].
  - frame_cnt increments on each strobe with dtout=10 or 11.
  - err_cnt increments on each frame_err pulse.
  - Both saturate at 0xFFFF and clear on rst.
- Macro undefined: neither the ports nor the counters exist.

Test Plan:
- Lock: 15 clean COMMAs -> link_ready stays 0; 16th -> link_ready=1 one cycle later.
  - A data byte at the 10th position resets the count, so lock then needs 16 further commas.
- Nominal frame: SOF, AA,1A,1B,1C,1D,1F,2A,2B,2C, EOF -> 9 strobes in order.
  - dtout=01 for AA, 00 for 1A..2B, 10 for 2C; no frame_err.
  - A COMMA inserted between 1C and 1D does not change the output.
- Single byte and empty: SOF,55,EOF -> one strobe, dout=55, dtout=11. SOF,EOF -> frame_err pulse, no strobe.
- Violations: SOF,AA,1A,SOF,2C,EOF -> frame_err at the second SOF.
  - AA is emitted (dtout=01) before the error; 1A is discarded; then 2C is emitted with dtout=11.
  - K28.0 inside a frame -> frame_err, return to IDLE.
- Overflow: MAX_LEN=4, SOF + 6 data bytes + EOF -> bytes 1-3 emitted, frame_err on the 5th byte, no dtout=10 strobe, back to IDLE after EOF.
- Lock loss: mid-frame, 4 consecutive rx_err symbols -> link_ready=0, single frame_err pulse.
  - Relock requires 16 commas; a subsequent nominal frame passes.

Source files
------------

// File: rtl/gtp_rx_deframer.sv
// Receive deframer for the GTP link: acquires comma lock, strips SOF/EOF and
// rebuilds the byte + type stream for the RX FIFO. Define RX_STATS_EN for frame/error counters.
module gtp_rx_deframer #(
  parameter int LOCK_COUNT = 16,
  parameter int ERR_LIMIT  = 4,
  parameter int MAX_LEN    = 256
) (
  input  logic       gtp_clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_charisk,
  input  logic       rx_err,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic [1:0] dtout,
  output logic       dout_we,
  output logic       link_ready,
  output logic       frame_err
`ifdef RX_STATS_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
`endif
);

  localparam int CW = $clog2(LOCK_COUNT + 1);
  localparam int EW = $clog2(ERR_LIMIT + 1);
  localparam int LW = $clog2(MAX_LEN + 1);

  localparam logic [7:0] K_COMMA = 8'hBC;
  localparam logic [7:0] K_SOF   = 8'hFB;
  localparam logic [7:0] K_EOF   = 8'hFD;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    IDLE     = 2'd1,
    IN_FRAME = 2'd2,
    DRAIN    = 2'd3
  } state_t;

  state_t          state;
  logic [CW-1:0]   comma_cnt;
  logic [EW-1:0]   err_run;
  logic [LW-1:0]   len;
  logic            hold_full;
  logic [7:0]      hold_data;

  logic is_comma, is_sof, is_eof, frame_data, hold_load, len_full;

  assign is_comma   = rx_charisk && (rx_data == K_COMMA);
  assign is_sof     = rx_charisk && (rx_data == K_SOF);
  assign is_eof     = rx_charisk && (rx_data == K_EOF);
  assign len_full   = (len == LW'(MAX_LEN));
  assign frame_data = rx_valid && !rx_err && !rx_charisk && (state == IN_FRAME);
  assign hold_load  = frame_data && !len_full;

  // Hold register: one byte of look-ahead so its type is known when it leaves
  always_ff @(posedge gtp_clk) begin
    if (hold_load) hold_data <= rx_data;
  end

  always_ff @(posedge gtp_clk) begin
    if (rst) begin
      state      <= UNLOCKED;
      comma_cnt  <= '0;
      err_run    <= '0;
      len        <= '0;
      hold_full  <= 1'b0;
      dout       <= 8'h00;
      dtout      <= 2'b00;
      dout_we    <= 1'b0;
      link_ready <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      dout_we   <= 1'b0;
      frame_err <= 1'b0;
      if (rx_valid) begin
        if (state == UNLOCKED) begin
          if (is_comma && !rx_err) begin
            if (comma_cnt == CW'(LOCK_COUNT - 1)) begin
              comma_cnt  <= '0;
              err_run    <= '0;
              link_ready <= 1'b1;
              state      <= IDLE;
            end else begin
              comma_cnt <= comma_cnt + CW'(1);
            end
          end else begin
            comma_cnt <= '0;
          end
        end else if (rx_err) begin
          // Corrupted symbols only feed the loss-of-lock run counter
          if (err_run == EW'(ERR_LIMIT - 1)) begin
            err_run    <= '0;
            comma_cnt  <= '0;
            len        <= '0;
            hold_full  <= 1'b0;
            link_ready <= 1'b0;
            state      <= UNLOCKED;
            if (state == IN_FRAME) frame_err <= 1'b1;
          end else begin
            err_run <= err_run + EW'(1);
          end
        end else begin
          err_run <= '0;
          case (state)
            IDLE: begin
              if (is_sof) begin
                len       <= '0;
                hold_full <= 1'b0;
                state     <= IN_FRAME;
              end else if (!is_comma) begin
                frame_err <= 1'b1;
              end
            end
            IN_FRAME: begin
              if (!rx_charisk) begin
                if (len_full) begin
                  frame_err <= 1'b1;
                  hold_full <= 1'b0;
                  len       <= '0;
                  state     <= DRAIN;
                end else begin
                  if (hold_full) begin
                    dout    <= hold_data;
                    dtout   <= (len == LW'(1)) ? 2'b01 : 2'b00;
                    dout_we <= 1'b1;
                  end
                  hold_full <= 1'b1;
                  len       <= len + LW'(1);
                end
              end else if (is_eof) begin
                if (hold_full) begin
                  dout    <= hold_data;
                  dtout   <= (len == LW'(1)) ? 2'b11 : 2'b10;
                  dout_we <= 1'b1;
                end else begin
                  frame_err <= 1'b1;
                end
                hold_full <= 1'b0;
                len       <= '0;
                state     <= IDLE;
              end else if (is_sof) begin
                frame_err <= 1'b1;
                hold_full <= 1'b0;
                len       <= '0;
              end else if (!is_comma) begin
                frame_err <= 1'b1;
                hold_full <= 1'b0;
                len       <= '0;
                state     <= IDLE;
              end
            end
            DRAIN: begin
              if (is_eof) begin
                state <= IDLE;
              end else if (is_sof) begin
                len       <= '0;
                hold_full <= 1'b0;
                state     <= IN_FRAME;
              end
            end
            default: state <= UNLOCKED;
          endcase
        end
      end
    end
  end

`ifdef RX_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Statistics stage: counts the registered strobes and error pulses
  always_ff @(posedge gtp_clk) begin
    if (rst) begin
      frame_cnt <= 16'd0;
      err_cnt   <= 16'd0;
    end else begin
      if (dout_we && dtout[1]) frame_cnt <= sat_inc(frame_cnt);
      if (frame_err) err_cnt <= sat_inc(err_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_gtp_rx_deframer.sv
// Bench for gtp_rx_deframer: two instances (MAX_LEN 256 and 4) share one symbol
// stream and are compared every cycle against a frame-buffer reference model.
module tb_gtp_rx_deframer;

  logic       gtp_clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_charisk;
  logic       rx_err;
  logic       rx_valid;

  logic [7:0] a_dout, b_dout;
  logic [1:0] a_dtout, b_dtout;
  logic       a_we, b_we, a_link, b_link, a_ferr, b_ferr;

  gtp_rx_deframer #(.LOCK_COUNT(16), .ERR_LIMIT(4), .MAX_LEN(256)) dut_a (
    .gtp_clk(gtp_clk), .rst(rst), .rx_data(rx_data), .rx_charisk(rx_charisk),
    .rx_err(rx_err), .rx_valid(rx_valid), .dout(a_dout), .dtout(a_dtout),
    .dout_we(a_we), .link_ready(a_link), .frame_err(a_ferr)
  );

  gtp_rx_deframer #(.LOCK_COUNT(16), .ERR_LIMIT(4), .MAX_LEN(4)) dut_b (
    .gtp_clk(gtp_clk), .rst(rst), .rx_data(rx_data), .rx_charisk(rx_charisk),
    .rx_err(rx_err), .rx_valid(rx_valid), .dout(b_dout), .dtout(b_dtout),
    .dout_we(b_we), .link_ready(b_link), .frame_err(b_ferr)
  );

  initial gtp_clk = 1'b0;
  always #5 gtp_clk = ~gtp_clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: the open frame is kept as a byte list; the last byte in the
  // list is released once the next symbol reveals whether it is first/middle/last.
  typedef enum int {M_UNLOCKED, M_IDLE, M_FRAME, M_DRAIN} mode_t;
  mode_t      mode [2];
  int         commas [2];
  int         errs [2];
  int         flen [2];
  logic [7:0] fbuf [2][0:511];
  logic [7:0] e_dout [2];
  logic [1:0] e_dtout [2];
  logic       e_we [2];
  logic       e_ferr [2];
  logic       e_link [2];

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      mode[i] = M_UNLOCKED; commas[i] = 0; errs[i] = 0; flen[i] = 0;
      e_dout[i] = 8'h00; e_dtout[i] = 2'b00; e_we[i] = 0; e_ferr[i] = 0; e_link[i] = 0;
    end
  endfunction

  function automatic void emit(int i, logic [7:0] d, logic [1:0] t);
    e_we[i] = 1; e_dout[i] = d; e_dtout[i] = t;
  endfunction

  function automatic void model_step(int i, int maxlen, logic v, logic k, logic [7:0] d, logic er);
    logic comma, sof, eof;
    comma = k && d == 8'hBC;
    sof   = k && d == 8'hFB;
    eof   = k && d == 8'hFD;
    e_we[i] = 0;
    e_ferr[i] = 0;
    if (!v) return;
    if (mode[i] == M_UNLOCKED) begin
      if (comma && !er) begin
        commas[i]++;
        if (commas[i] == 16) begin
          mode[i] = M_IDLE; e_link[i] = 1; commas[i] = 0; errs[i] = 0;
        end
      end else commas[i] = 0;
      return;
    end
    if (er) begin
      errs[i]++;
      if (errs[i] == 4) begin
        if (mode[i] == M_FRAME) e_ferr[i] = 1;
        mode[i] = M_UNLOCKED; e_link[i] = 0; commas[i] = 0; errs[i] = 0; flen[i] = 0;
      end
      return;
    end
    errs[i] = 0;
    case (mode[i])
      M_IDLE: begin
        if (sof) begin mode[i] = M_FRAME; flen[i] = 0; end
        else if (!comma) e_ferr[i] = 1;
      end
      M_FRAME: begin
        if (!k) begin
          if (flen[i] == maxlen) begin
            e_ferr[i] = 1; mode[i] = M_DRAIN; flen[i] = 0;
          end else begin
            if (flen[i] > 0) emit(i, fbuf[i][flen[i]-1], (flen[i] == 1) ? 2'b01 : 2'b00);
            fbuf[i][flen[i]] = d;
            flen[i]++;
          end
        end else if (eof) begin
          if (flen[i] > 0) emit(i, fbuf[i][flen[i]-1], (flen[i] == 1) ? 2'b11 : 2'b10);
          else e_ferr[i] = 1;
          mode[i] = M_IDLE; flen[i] = 0;
        end else if (sof) begin
          e_ferr[i] = 1; flen[i] = 0;
        end else if (!comma) begin
          e_ferr[i] = 1; mode[i] = M_IDLE; flen[i] = 0;
        end
      end
      M_DRAIN: begin
        if (eof) mode[i] = M_IDLE;
        else if (sof) begin mode[i] = M_FRAME; flen[i] = 0; end
      end
      default: ;
    endcase
  endfunction

  task automatic compare();
    chk("a_we", a_we, e_we[0]);
    chk("a_ferr", a_ferr, e_ferr[0]);
    chk("a_link", a_link, e_link[0]);
    chk("a_dout", a_dout, e_dout[0]);
    chk("a_dtout", a_dtout, e_dtout[0]);
    chk("b_we", b_we, e_we[1]);
    chk("b_ferr", b_ferr, e_ferr[1]);
    chk("b_link", b_link, e_link[1]);
    chk("b_dout", b_dout, e_dout[1]);
    chk("b_dtout", b_dtout, e_dtout[1]);
  endtask

  task automatic send(input logic v, input logic k, input logic [7:0] d, input logic er);
    @(negedge gtp_clk);
    rx_valid = v; rx_charisk = k; rx_data = d; rx_err = er;
    model_step(0, 256, v, k, d, er);
    model_step(1, 4, v, k, d, er);
    @(posedge gtp_clk);
    #1;
    compare();
  endtask

  task automatic comma();            send(1'b1, 1'b1, 8'hBC, 1'b0); endtask
  task automatic sof();              send(1'b1, 1'b1, 8'hFB, 1'b0); endtask
  task automatic eof();              send(1'b1, 1'b1, 8'hFD, 1'b0); endtask
  task automatic dat(input logic [7:0] d); send(1'b1, 1'b0, d, 1'b0); endtask
  task automatic errsym();           send(1'b1, 1'b1, 8'hBC, 1'b1); endtask

  task automatic do_reset();
    @(negedge gtp_clk);
    rst = 1'b1; rx_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge gtp_clk);
    #1;
    compare();
    @(negedge gtp_clk);
    rst = 1'b0;
  endtask

  task automatic nominal_frame();
    sof();
    dat(8'hAA); dat(8'h1A); dat(8'h1B); dat(8'h1C);
    comma();
    dat(8'h1D); dat(8'h1F); dat(8'h2A); dat(8'h2B); dat(8'h2C);
    eof();
  endtask

  initial begin
    int r;
    rst = 1'b1; rx_valid = 1'b0; rx_charisk = 1'b0; rx_data = 8'h00; rx_err = 1'b0;
    model_reset();
    repeat (2) @(posedge gtp_clk);
    #1;
    compare();
    @(negedge gtp_clk);
    rst = 1'b0;

    // Lock acquisition, interrupted by a data byte at position 10
    repeat (9) comma();
    dat(8'h11);
    repeat (15) comma();
    chk("lock15", a_link, 1'b0);
    comma();
    chk("lock16", a_link, 1'b1);

    nominal_frame();
    chk("nom_last_dout", a_dout, 8'h2C);
    chk("nom_last_type", a_dtout, 2'b10);

    sof(); dat(8'h55); eof();
    chk("single_dout", a_dout, 8'h55);
    chk("single_type", a_dtout, 2'b11);
    sof(); eof();
    chk("empty_ferr", a_ferr, 1'b1);

    sof(); dat(8'hAA); dat(8'h1A); sof();
    chk("resof_ferr", a_ferr, 1'b1);
    dat(8'h2C); eof();
    chk("resof_type", a_dtout, 2'b11);

    sof(); dat(8'h11); send(1'b1, 1'b1, 8'h1C, 1'b0);
    chk("illk_ferr", a_ferr, 1'b1);
    dat(8'h22);
    send(1'b0, 1'b1, 8'hFB, 1'b0);

    sof();
    for (int i = 1; i <= 6; i++) dat(8'(8'h40 + i));
    eof();

    sof(); dat(8'h31); dat(8'h32);
    repeat (4) errsym();
    chk("loss_link", a_link, 1'b0);
    repeat (16) comma();
    nominal_frame();

    sof(); dat(8'h41); dat(8'h42);
    do_reset();
    repeat (16) comma();
    nominal_frame();

    for (int n = 0; n < 3000; n++) begin
      if (!e_link[0]) repeat (16) comma();
      r = $urandom_range(0, 99);
      if (r < 2)       repeat (4) errsym();
      else if (r < 10) send(1'b0, 1'($urandom), 8'($urandom), 1'($urandom));
      else if (r < 14) send(1'b1, 1'($urandom), 8'($urandom), 1'b1);
      else if (r < 22) comma();
      else if (r < 30) sof();
      else if (r < 38) eof();
      else if (r < 40) send(1'b1, 1'b1, 8'h1C, 1'b0);
      else             dat(8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
